// File: rtl/gate_mux_pkg.sv
// Shared constants for the gate/mux logic slice: selector encodings and one-hot width.
package gate_mux_pkg;

    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_XOR  = 2'b10;
    localparam logic [1:0] SEL_NAND = 2'b11;

    localparam int ONEHOT_W = 4;

endpackage

// File: rtl/sel_decoder_2to4.sv
// Combinational 2-to-4 selector decoder with enable; all-zero output when disabled.
module sel_decoder_2to4
    import gate_mux_pkg::*;
(
    input  logic                enable,
    input  logic [1:0]          sel,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (enable) begin
            case (sel)
                SEL_AND:  onehot = 4'b0001;
                SEL_OR:   onehot = 4'b0010;
                SEL_XOR:  onehot = 4'b0100;
                SEL_NAND: onehot = 4'b1000;
                default:  onehot = '0;
            endcase
        end
    end

endmodule

// File: rtl/gate_mux_unit.sv
// Bitwise AND/OR/XOR/NAND slice with one-hot selected, registered result.
// Optional ZERO_FLAG_EN adds a registered zero_flag output alongside mux_out.
module gate_mux_unit
    import gate_mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                dec_enable,
    input  logic [1:0]          dec_selector,
    output logic [WIDTH-1:0]    and_out,
    output logic [WIDTH-1:0]    or_out,
    output logic [WIDTH-1:0]    xor_out,
    output logic [WIDTH-1:0]    nand_out,
    output logic [ONEHOT_W-1:0] dec_onehot,
`ifdef ZERO_FLAG_EN
    output logic                zero_flag,
`endif
    output logic [WIDTH-1:0]    mux_out
);

    logic [ONEHOT_W-1:0] onehot_p0;
    logic [WIDTH-1:0]    mux_p0;
    logic [ONEHOT_W-1:0] onehot_p1;
    logic [WIDTH-1:0]    mux_p1;

    // Stage p0: gates, decode and AND-OR mux, all combinational
    assign and_out  = a & b;
    assign or_out   = a | b;
    assign xor_out  = a ^ b;
    assign nand_out = ~(a & b);

    sel_decoder_2to4 u_dec (
        .enable (dec_enable),
        .sel    (dec_selector),
        .onehot (onehot_p0)
    );

    assign mux_p0 = ({WIDTH{onehot_p0[SEL_AND]}}  & and_out)
                  | ({WIDTH{onehot_p0[SEL_OR]}}   & or_out)
                  | ({WIDTH{onehot_p0[SEL_XOR]}}  & xor_out)
                  | ({WIDTH{onehot_p0[SEL_NAND]}} & nand_out);

    // Stage p1: output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            onehot_p1 <= '0;
            mux_p1    <= '0;
        end else begin
            onehot_p1 <= onehot_p0;
            mux_p1    <= mux_p0;
        end
    end

    assign dec_onehot = onehot_p1;
    assign mux_out    = mux_p1;

`ifdef ZERO_FLAG_EN
    logic zero_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_p1 <= 1'b1;
        end else begin
            zero_p1 <= (mux_p0 == '0);
        end
    end

    assign zero_flag = zero_p1;
`endif

endmodule

// File: tb/tb_gate_mux_unit.sv
// Self-checking bench for gate_mux_unit: directed steps then randomized cycles vs a reference model.
module tb_gate_mux_unit;

    logic       clk;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic       dec_enable;
    logic [1:0] dec_selector;
    logic [3:0] and_out;
    logic [3:0] or_out;
    logic [3:0] xor_out;
    logic [3:0] nand_out;
    logic [3:0] dec_onehot;
    logic [3:0] mux_out;
`ifdef ZERO_FLAG_EN
    logic       zero_flag;
`endif

    int checks = 0;
    int errors = 0;

    gate_mux_unit #(.WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .b            (b),
        .dec_enable   (dec_enable),
        .dec_selector (dec_selector),
        .and_out      (and_out),
        .or_out       (or_out),
        .xor_out      (xor_out),
        .nand_out     (nand_out),
        .dec_onehot   (dec_onehot),
`ifdef ZERO_FLAG_EN
        .zero_flag    (zero_flag),
`endif
        .mux_out      (mux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check the gates at once and the registers after the edge.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb_v, input logic en,
                        input logic [1:0] s, input logic r);
        logic [3:0] res [4];
        logic [3:0] exp_oh;
        logic [3:0] exp_mux;
        a = ta; b = tb_v; dec_enable = en; dec_selector = s; reset = r;
        #1;
        res[0] = ta & tb_v;
        res[1] = ta | tb_v;
        res[2] = ta ^ tb_v;
        res[3] = ~(ta & tb_v);
        check("and_out",  and_out,  res[0]);
        check("or_out",   or_out,   res[1]);
        check("xor_out",  xor_out,  res[2]);
        check("nand_out", nand_out, res[3]);
        if (r || !en) begin
            exp_oh  = 4'b0000;
            exp_mux = 4'b0000;
        end else begin
            exp_oh  = 4'(1 << s);
            exp_mux = res[s];
        end
        @(posedge clk);
        #1;
        check("dec_onehot", dec_onehot, exp_oh);
        check("mux_out",    mux_out,    exp_mux);
`ifdef ZERO_FLAG_EN
        checks++;
        assert (zero_flag === (r ? 1'b1 : (exp_mux == 4'b0000))) else begin
            errors++;
            $error("FAIL zero_flag observed=%b expected=%b", zero_flag, (r ? 1'b1 : (exp_mux == 4'b0000)));
        end
`endif
    endtask

    initial begin
        a = '0; b = '0; dec_enable = 1'b0; dec_selector = '0; reset = 1'b1;

        step(4'b0000, 4'b0000, 1'b1, 2'b01, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 2'b01, 1'b1);

        step(4'b1001, 4'b0001, 1'b1, 2'b00, 1'b0);
        step(4'b1001, 4'b0001, 1'b1, 2'b01, 1'b0);
        step(4'b1001, 4'b0001, 1'b1, 2'b10, 1'b0);
        step(4'b1001, 4'b0001, 1'b1, 2'b11, 1'b0);

        step(4'b1111, 4'b1111, 1'b0, 2'b11, 1'b0);

        step(4'b1010, 4'b0101, 1'b1, 2'b01, 1'b0);
        step(4'b1010, 4'b0101, 1'b1, 2'b01, 1'b1);
        step(4'b1010, 4'b0101, 1'b1, 2'b01, 1'b0);

        step(4'b0110, 4'b0110, 1'b1, 2'b10, 1'b0);
        step(4'b0111, 4'b0110, 1'b1, 2'b10, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                 2'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
